// File: rtl/instruction_fetch_stage.sv
// PC register, instruction-memory handshake and IF/ID pipeline register.
// Handles stall, flush and EX branch/jump redirect, including in-flight fetches.
module instruction_fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  output logic [31:0] IMemAddr,
  output logic        IMemReq,
  input  logic        IMemRdy,
  input  logic [31:0] IMemData,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic [15:0] Imm16
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HELD,
    DISCARD
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
    logic        valid;
  } if_id_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] skid, skid_n;
  logic [31:0] redir, redir_n;
  if_id_t      ifid, ifid_n;

  logic [31:0] pc4;
  logic [31:0] tgt;

  assign pc4 = pc + 32'd4;
  assign tgt = {BranchTarget[31:2], 2'b00};

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      pc    <= PC_RESET;
      skid  <= '0;
      redir <= '0;
      ifid  <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      skid  <= skid_n;
      redir <= redir_n;
      ifid  <= ifid_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    skid_n  = skid;
    redir_n = redir;
    ifid_n  = ifid;
    if (BranchTaken) begin
      ifid_n.valid = 1'b0;
      skid_n       = '0;
      // an outstanding request must complete before the new PC is issued
      if ((state == FETCH || state == DISCARD) && !IMemRdy) begin
        redir_n = tgt;
        state_n = DISCARD;
      end else begin
        pc_n    = tgt;
        state_n = FETCH;
      end
    end else begin
      unique case (state)
        IDLE: state_n = FETCH;
        FETCH: begin
          if (IMemRdy) begin
            if (Flush || !Stall) begin
              pc_n = pc4;
              if (!Flush) ifid_n = '{IMemData, pc4, 1'b1};
            end else begin
              skid_n  = IMemData;
              state_n = HELD;
            end
          end else if (!Stall) begin
            ifid_n.valid = 1'b0;
          end
        end
        HELD: begin
          if (Flush || !Stall) begin
            pc_n    = pc4;
            state_n = FETCH;
            skid_n  = '0;
            if (!Flush) ifid_n = '{skid, pc4, 1'b1};
          end
        end
        DISCARD: begin
          ifid_n.valid = 1'b0;
          if (IMemRdy) begin
            pc_n    = redir;
            state_n = FETCH;
          end
        end
      endcase
      if (Flush) ifid_n.valid = 1'b0;
    end
  end

  assign IMemAddr      = pc;
  assign IMemReq       = (state == FETCH) || (state == DISCARD);
  assign IF_ID_Instr   = ifid.instr;
  assign IF_ID_PCPlus4 = ifid.pcplus4;
  assign IF_ID_Valid   = ifid.valid;
  assign Imm16         = ifid.instr[15:0];

endmodule
